// File: rtl/dma_burst_device_if.sv
// Bus between the DMA controller (master) and the burst device (slave).
interface dma_burst_device_if #(
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 64
);
    logic [OFFSET_W-1:0] offset;
    logic                rd_en;
    logic                xfer_done;
    logic                interrupt;
    logic [DATA_W-1:0]   data;
    logic                data_valid;
    logic                offset_err;
    logic [7:0]          burst_cnt;

    // rd_en/offset and xfer_done are single-cycle strobes sampled on the rising edge and
    // are never back-pressured; each accepted read is answered one cycle later by exactly
    // one of data_valid or offset_err.
    modport master (
        output offset, rd_en, xfer_done,
        input  interrupt, data, data_valid, offset_err, burst_cnt
    );
    modport slave (
        input  offset, rd_en, xfer_done,
        output interrupt, data, data_valid, offset_err, burst_cnt
    );
endinterface

// File: rtl/dma_burst_device.sv
// Clocked external burst device for DMA bring-up: fill, count, interrupt, serve reads, re-arm.
// Define LFSR_FILL_EN to fill storage from a 16-bit Galois LFSR instead of the indexed pattern.
module dma_burst_device #(
    parameter int          WORD_SIZE   = 16,
    parameter int          BLOCK_WORDS = 4,
    parameter int          NUM_BLOCKS  = 3,
    parameter int          OFFSET_W    = 2,
    parameter int          FIRE_CYCLES = 179,
    parameter int          INT_CYCLES  = 1,
    parameter int          NUM_BURSTS  = 2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset_n,
    dma_burst_device_if.slave   bus,
    output logic [2:0]          dbg_state
);
    localparam int DATA_W  = BLOCK_WORDS * WORD_SIZE;
    localparam int BLK_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int WRD_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int MAX_CYC = (FIRE_CYCLES > INT_CYCLES) ? FIRE_CYCLES : INT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {RELOAD, COUNT, FIRE, SERVE, HALT} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BLK_W-1:0]     fill_blk_q, fill_blk_d;
    logic [WRD_W-1:0]     fill_wrd_q, fill_wrd_d;
    logic                 interrupt_q, interrupt_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 offset_err_q, offset_err_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;

    logic [WORD_SIZE-1:0] mem_q [NUM_BLOCKS][BLOCK_WORDS];
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 fill_last;
    logic [DATA_W-1:0]    rd_block;
    logic                 rd_in_range;

`ifdef LFSR_FILL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Word written is the LFSR value before its step; the state carries across bursts.
    always_comb begin
        lfsr_d = lfsr_q;
        if (mem_we) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        mem_wdata = WORD_SIZE'(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // burst_cnt_q already holds the post-increment count while RELOAD runs.
    always_comb begin
        mem_wdata = WORD_SIZE'((32'(burst_cnt_q) << 8) | (32'(fill_blk_q) << 4) | 32'(fill_wrd_q));
    end
`endif

    always_comb begin
        rd_block    = '0;
        rd_in_range = 1'b0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (bus.offset == OFFSET_W'(b)) begin
                rd_in_range = 1'b1;
                for (int w = 0; w < BLOCK_WORDS; w++) begin
                    rd_block[w*WORD_SIZE +: WORD_SIZE] = mem_q[b][w];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_blk_d   = fill_blk_q;
        fill_wrd_d   = fill_wrd_q;
        interrupt_d  = interrupt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        offset_err_d = 1'b0;
        burst_cnt_d  = burst_cnt_q;
        mem_we       = 1'b0;
        fill_last    = (fill_blk_q == BLK_W'(NUM_BLOCKS - 1)) &&
                       (fill_wrd_q == WRD_W'(BLOCK_WORDS - 1));

        case (state_q)
            RELOAD: begin
                mem_we = 1'b1;
                if (fill_wrd_q == WRD_W'(BLOCK_WORDS - 1)) begin
                    fill_wrd_d = '0;
                    fill_blk_d = fill_blk_q + 1'b1;
                end else begin
                    fill_wrd_d = fill_wrd_q + 1'b1;
                end
                if (fill_last) begin
                    state_d    = COUNT;
                    cnt_d      = '0;
                    fill_blk_d = '0;
                    fill_wrd_d = '0;
                end
            end
            COUNT: begin
                if (cnt_q == CNT_W'(FIRE_CYCLES - 1)) begin
                    state_d     = FIRE;
                    cnt_d       = '0;
                    interrupt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIRE: begin
                if (cnt_q == CNT_W'(INT_CYCLES - 1)) begin
                    state_d     = SERVE;
                    cnt_d       = '0;
                    interrupt_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SERVE: begin
                if (bus.xfer_done) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if ((NUM_BURSTS != 0) && (burst_cnt_d == 8'(NUM_BURSTS))) begin
                        state_d = HALT;
                    end else begin
                        state_d = RELOAD;
                    end
                end
            end
            HALT: begin
                interrupt_d = 1'b0;
            end
            default: begin
                state_d = RELOAD;
            end
        endcase

        // A read alongside xfer_done in SERVE is still answered from the finishing burst.
        if (((state_q == FIRE) || (state_q == SERVE)) && bus.rd_en) begin
            if (rd_in_range) begin
                data_d       = rd_block;
                data_valid_d = 1'b1;
            end else begin
                data_d       = '0;
                offset_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RELOAD;
            cnt_q        <= '0;
            fill_blk_q   <= '0;
            fill_wrd_q   <= '0;
            interrupt_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            offset_err_q <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_blk_q   <= fill_blk_d;
            fill_wrd_q   <= fill_wrd_d;
            interrupt_q  <= interrupt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            offset_err_q <= offset_err_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[fill_blk_q][fill_wrd_q] <= mem_wdata;
        end
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.offset_err = offset_err_q;
    assign bus.burst_cnt  = burst_cnt_q;
    assign dbg_state      = state_q;
endmodule
